// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and constants for the parking request scheduler
package parking_pkg;

    localparam int PLATE_W = 16;
    localparam int FLOOR_W = 3;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_IN   = 2'd1,
        CMD_OUT  = 2'd2,
        CMD_LEAK = 2'd3
    } cmd_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    typedef struct packed {
        cmd_type_t            typ;
        logic [PLATE_W-1:0]   plate;
        logic [FLOOR_W-1:0]   floor;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic cmd_t make_cmd(input cmd_type_t typ,
                                      input logic [PLATE_W-1:0] plate,
                                      input logic [FLOOR_W-1:0] floor);
        cmd_t c;
        c.typ   = typ;
        c.plate = plate;
        c.floor = floor;
        return c;
    endfunction

endpackage

// File: rtl/parking_req_fifo.sv
// rtl/parking_req_fifo.sv - synchronous request FIFO; a push into a full FIFO is taken only alongside a pop
module parking_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/parking_request_scheduler.sv
// rtl/parking_request_scheduler.sv - queues in/out requests and leak events, offers one command at a time to the elevator
module parking_request_scheduler #(
    parameter int DEPTH   = 4,
    parameter int PLATE_W = parking_pkg::PLATE_W,
    parameter int FLOOR_W = parking_pkg::FLOOR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PLATE_W-1:0] license_plate,
    input  logic               in_mode,
    input  logic               out_mode,
    input  logic               leakage,
    input  logic [FLOOR_W-1:0] leakage_floor,
    input  logic               todo_accept,
    input  logic               todo_done,
    output logic               todo_exists,
    output logic               todo_in,
    output logic               todo_out,
    output logic               todo_leak_move,
    output logic [PLATE_W-1:0] todo_license_plate,
    output logic [FLOOR_W-1:0] todo_floor,
    output logic               busy,
    output logic               req_drop,
    output logic [7:0]         drop_count
);
    import parking_pkg::*;

    state_t             r_state;
    state_t             w_state_next;
    cmd_t               r_cur;
    cmd_t               w_offer;
    cmd_t               w_out;
    cmd_t               w_fifo_head;
    cmd_t               w_push_cmd;
    logic [CMD_W-1:0]   w_fifo_head_bits;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_offer_valid;
    logic               w_accept;
    logic               w_pop;
    logic               w_leak_taken;
    logic               w_req_ok;
    logic               w_push;
    logic               w_drop;
    logic               w_leak_event;
    logic               r_leak_pending;
    logic               r_leak_prev;
    logic [FLOOR_W-1:0] r_leak_floor;
    logic [FLOOR_W-1:0] r_leak_floor_prev;
    logic               r_req_drop;
    logic [7:0]         r_drop_count;

    assign w_req_ok = (in_mode ^ out_mode) && (license_plate != '0);
    assign w_push   = w_req_ok && (!w_fifo_full || w_pop);
    assign w_drop   = (in_mode || out_mode) && !w_push;

    always_comb begin
        w_push_cmd = make_cmd(CMD_OUT, license_plate, '0);
        if (in_mode) begin
            w_push_cmd = make_cmd(CMD_IN, license_plate, '0);
        end
    end

    parking_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head_bits),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_fifo_head = cmd_t'(w_fifo_head_bits);

    // A held leak recaptures only when it re-rises or moves to another floor.
    assign w_leak_event = leakage && (!r_leak_prev || (leakage_floor != r_leak_floor_prev));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_leak_prev       <= 1'b0;
            r_leak_floor_prev <= '0;
            r_leak_pending    <= 1'b0;
            r_leak_floor      <= '0;
        end else begin
            r_leak_prev       <= leakage;
            r_leak_floor_prev <= leakage_floor;
            if (w_leak_event) begin
                r_leak_pending <= 1'b1;
                r_leak_floor   <= leakage_floor;
            end else if (w_leak_taken || !leakage) begin
                r_leak_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_offer = '0;
        if (r_leak_pending) begin
            w_offer = make_cmd(CMD_LEAK, '0, r_leak_floor);
        end else if (!w_fifo_empty) begin
            w_offer = w_fifo_head;
        end
    end

    assign w_offer_valid = r_leak_pending || !w_fifo_empty;
    assign w_pop         = w_accept && !r_leak_pending;
    assign w_leak_taken  = w_accept && r_leak_pending;

    always_comb begin
        w_state_next = r_state;
        w_out        = '0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_offer_valid) begin
                    w_state_next = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (w_offer_valid) begin
                    w_out = w_offer;
                    if (todo_accept) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_BUSY;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                w_out = r_cur;
                if (todo_done) begin
                    w_state_next = w_offer_valid ? ST_OFFER : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cur        <= '0;
            r_req_drop   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_req_drop <= w_drop;
            if (w_accept) begin
                r_cur <= w_offer;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign todo_exists        = (w_out.typ != CMD_NONE);
    assign todo_in            = (w_out.typ == CMD_IN);
    assign todo_out           = (w_out.typ == CMD_OUT);
    assign todo_leak_move     = (w_out.typ == CMD_LEAK);
    assign todo_license_plate = w_out.plate;
    assign todo_floor         = w_out.floor;
    assign busy               = (r_state == ST_BUSY);
    assign req_drop           = r_req_drop;
    assign drop_count         = r_drop_count;

endmodule
